// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program-memory instruction sequencer feeding a multi-cycle processor
// Optional watchdog: define SEQ_WATCHDOG_EN to add the WAIT timeout counter and the error port.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          done,
  output logic [15:0]   instr,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished
`ifdef SEQ_WATCHDOG_EN
  ,
  output logic          error
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] mem [DEPTH];
  logic [AW:0] len_q;
  logic        start_ok;
  logic        last;
  logic        advance;

  // start is only honoured from IDLE; the length is latched there so later changes have no effect
  assign start_ok = (state == IDLE) && start;
  // len_q is at least 1 whenever WAIT is reachable, so the subtraction cannot underflow there
  assign last     = ({1'b0, pc} == (len_q - LEN_ONE));
  assign advance  = (state == WAIT) && done && !last;

  assign run      = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign finished = (state == FIN);

`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_ONE  = WW'(1);

  logic [WW-1:0] wd_cnt;
  logic          wd_fire;

  // fires on the TIMEOUT-th consecutive WAIT cycle without done
  assign wd_fire = (state == WAIT) && !done && (wd_cnt == WD_LAST);

  // watchdog counter restarts on every issue; error is sticky until the next accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      error  <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if ((state == WAIT) && !done) begin
        wd_cnt <= wd_cnt + WD_ONE;
      end
      if (start_ok) begin
        error <= 1'b0;
      end else if (wd_fire) begin
        error <= 1'b1;
      end
    end
  end
`endif

  // program memory is deliberately not reset; writes are accepted only while idle
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode: done only matters in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (prog_len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          state_nxt = last ? FIN : ISSUE;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_fire) begin
          state_nxt = IDLE;
        end
`endif
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pc / instr / length registers; instr only changes when a new instruction is loaded so the
  // processor sees a stable word for the whole instruction, and it holds through FIN and IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      instr <= '0;
      len_q <= '0;
    end else if (start_ok) begin
      pc    <= '0;
      len_q <= (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
      // a same-cycle write to address 0 must be the word that gets issued
      instr <= (wr_en && (wr_addr == '0)) ? wr_data : mem[0];
    end else if (advance) begin
      pc    <= pc + PC_ONE;
      instr <= mem[pc + PC_ONE];
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a processor stub
module tb_instr_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 15;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          done;
  logic [15:0]   instr;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
`ifdef SEQ_WATCHDOG_EN
  logic          error;
`endif

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .prog_len(prog_len),
    .start(start),
    .done(done),
    .instr(instr),
    .run(run),
    .pc(pc),
    .busy(busy),
    .finished(finished)
`ifdef SEQ_WATCHDOG_EN
    ,
    .error(error)
`endif
  );

  typedef struct {
    int          pc;
    logic [15:0] word;
    int          cyc;
  } issue_t;

  issue_t      iss_q[$];
  int          fin_q[$];
  logic [15:0] tb_mem [DEPTH];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          run_count = 0;
  int          busy_cycles = 0;
  int          fin_count = 0;
  logic [15:0] cur_instr = '0;
  int          r0 = 0;
  int          r1 = 0;
  bit          hang = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d cycles required=finish", cyc);
    $fatal(1);
  end

  // processor timing: top nibble 6/7 are 4-cycle ALU ops, everything else a 2-cycle move
  function automatic int lat(input logic [15:0] w);
    return (w[15:12] == 4'h6 || w[15:12] == 4'h7) ? 4 : 2;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [3:0] ops [4] = '{4'h2, 4'h3, 4'h6, 4'h7};
    return {ops[$urandom_range(0, 3)], 4'h0, 8'($urandom_range(0, 255))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // processor stub: executes the issued word and raises done in its final cycle
  initial begin
    int w;
    bit pending;
    logic [15:0] pw;
    w = 0;
    pending = 0;
    pw = '0;
    done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (!reset) begin
        pending = 0;
      end else if (run) begin
        pending = 1;
        pw = instr;
        w = lat(instr) - 1;
      end else if (pending && !hang) begin
        w--;
        if (w == 0) begin
          done = 1'b1;
          pending = 0;
          case (pw[15:12])
            4'h2: r0 = int'(pw[7:0]);
            4'h3: r1 = int'(pw[7:0]);
            4'h6: r0 = r0 + int'(pw[7:0]);
            4'h7: r1 = r1 + int'(pw[7:0]);
            default: ;
          endcase
        end
      end
    end
  end

  // monitor: pops the scoreboard on every run / finished pulse and checks instr stability in WAIT
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (busy) busy_cycles++;
      if (run) begin
        run_count++;
        check("run_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          issue_t e;
          e = iss_q.pop_front();
          check("run_pc", pc, e.pc);
          check("run_instr", instr, e.word);
          check("run_cycle", cyc, e.cyc);
          cur_instr = e.word;
        end
      end else if (busy && !finished) begin
        check("instr_hold", instr, cur_instr);
      end
      if (finished) begin
        fin_count++;
        check("fin_expected", fin_q.size() > 0, 1);
        if (fin_q.size() > 0) check("fin_cycle", cyc, fin_q.pop_front());
      end
    end
  end

  task automatic write_mem(input int addr, input logic [15:0] data);
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    tb_mem[addr] = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // reference: run k issues at start+1+sum of earlier latencies; finished follows the last latency
  task automatic launch(input int len, input bit wr, input int addr, input logic [15:0] data,
                        input bit expect_fin, output int t_fin);
    int eff;
    int t;
    issue_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    prog_len = (AW+1)'(len);
    if (wr) begin
      wr_en = 1'b1;
      wr_addr = AW'(addr);
      wr_data = data;
      tb_mem[addr] = data;
    end
    eff = (len > DEPTH) ? DEPTH : len;
    t = cyc + 1;
    for (int i = 0; i < eff; i++) begin
      e.pc = i;
      e.word = tb_mem[i];
      e.cyc = t;
      iss_q.push_back(e);
      t += lat(tb_mem[i]);
    end
    t_fin = t;
    if (expect_fin) fin_q.push_back(t_fin);
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic drain(input int t_fin);
    while (cyc <= t_fin + 1) @(posedge clk);
    #1;
    check("iss_q_drained", iss_q.size(), 0);
    check("fin_q_drained", fin_q.size(), 0);
  endtask

  initial begin
    int tf;
    int rc;
    int bc;
    int fc;
    int t0;
    int guard;
    reset = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    prog_len = '0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_run", run, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    reset = 1'b1;

    // mv r0,#5 ; mv r1,#3
    write_mem(0, 16'h2005);
    write_mem(1, 16'h3003);
    launch(2, 0, 0, '0, 1, tf);
    drain(tf);
    check("scn1_r0", r0, 5);
    check("scn1_r1", r1, 3);

    // mv r0,#4 ; add r0,#2
    write_mem(0, 16'h2004);
    write_mem(1, 16'h6002);
    launch(2, 0, 0, '0, 1, tf);
    drain(tf);
    check("scn2_r0", r0, 6);

    // empty program
    rc = run_count;
    bc = busy_cycles;
    launch(0, 0, 0, '0, 1, tf);
    drain(tf);
    check("len0_busy_cycles", busy_cycles - bc, 1);
    check("len0_no_run", run_count, rc);

    for (int i = 0; i < DEPTH; i++) write_mem(i, rand_word());

    // start and write while busy are both ignored
    launch(3, 0, 0, '0, 1, tf);
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = AW'(1);
    wr_data = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    drain(tf);
    launch(2, 0, 0, '0, 1, tf);
    drain(tf);

    // write to address 0 in the same cycle as start is issued
    launch(2, 1, 0, rand_word(), 1, tf);
    drain(tf);

    // oversize length clamps to DEPTH
    launch(DEPTH + 4, 0, 0, '0, 1, tf);
    drain(tf);

    for (int n = 0; n < 6; n++) begin
      write_mem($urandom_range(0, DEPTH - 1), rand_word());
      launch($urandom_range(1, DEPTH), 0, 0, '0, 1, tf);
      drain(tf);
    end

    // reset during WAIT of instruction 2 of 4
    rc = run_count;
    launch(4, 0, 0, '0, 1, tf);
    guard = 0;
    while (run_count < rc + 2 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reset_reach_instr2", run_count - rc, 2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort_pc", pc, 0);
    check("abort_instr", instr, 0);
    check("abort_run", run, 0);
    check("abort_busy", busy, 0);
    check("abort_finished", finished, 0);
    iss_q.delete();
    fin_q.delete();
    rc = run_count;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_run", run_count, rc);
    launch(4, 0, 0, '0, 1, tf);
    drain(tf);

`ifdef SEQ_WATCHDOG_EN
    hang = 1;
    fc = fin_count;
    launch(1, 0, 0, '0, 0, tf);
    t0 = tf - lat(tb_mem[0]) - 1;
    guard = 0;
    while (error !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("wd_error_set", error, 1);
    check("wd_error_cycle", cyc, t0 + 2 + TIMEOUT);
    check("wd_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("wd_no_finished", fin_count, fc);
    check("wd_error_sticky", error, 1);
    hang = 0;
    launch(1, 0, 0, '0, 1, tf);
    check("wd_error_cleared", error, 0);
    drain(tf);
`else
    fc = fin_count;
    t0 = cyc;
    check("fin_count_total", fin_count, fc);
    check("cycle_progress", cyc >= t0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
